// File: rtl/lsu_gen.sv
// Load/store unit between the execute stage and data RAM: byte-lane stores,
// extending loads, misalignment checks, one tagged transaction in flight.
module lsu_gen #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24,
    parameter int TAG_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              i_flush,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_load,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_signed,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [TAG_W-1:0]  i_req_tag,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic [DATA_W/8-1:0] o_mem_wr,
    output logic [DATA_W-1:0] o_mem_dout,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_din,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [TAG_W-1:0]  o_rsp_tag,
    output logic              o_rsp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, MEM, RSP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OFS_W-1:0]   req_ofs;
    logic [OFS_W-1:0]   size_mask;
    logic               req_bad;
    logic               accept;
    logic [LANES-1:0]   lane_mask;
    logic [LANES-1:0]   wr_lanes;
    logic [DATA_W-1:0]  wr_data;
    logic [1:0]         size_q;
    logic               signed_q;
    logic               load_q;
    logic [OFS_W-1:0]   ofs_q;
    logic               flushed;
    logic [DATA_W-1:0]  shifted;
    logic               sign_bit;
    logic [DATA_W-1:0]  ld_data;

    assign req_ofs     = i_req_addr[OFS_W-1:0];
    assign accept      = i_req_valid && (state == IDLE);
    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RSP);

    // Alignment check; a dword needs 8 lanes, so it is illegal on a 32-bit bus.
    always_comb begin
        size_mask = '0;
        case (i_req_size)
            2'd0:    size_mask = '0;
            2'd1:    size_mask = OFS_W'(1);
            2'd2:    size_mask = OFS_W'(3);
            default: size_mask = OFS_W'(7);
        endcase
        req_bad = ((req_ofs & size_mask) != '0) || ((i_req_size == 2'd3) && (LANES < 8));
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (i < (1 << i_req_size));
        end
        wr_lanes = lane_mask << req_ofs;
        wr_data  = i_req_wdata << {req_ofs, 3'b000};
    end

    // Load alignment and extension, using the offset and size latched at accept.
    always_comb begin
        shifted  = i_mem_din >> {ofs_q, 3'b000};
        sign_bit = 1'b0;
        case (size_q)
            2'd0:    sign_bit = shifted[7];
            2'd1:    sign_bit = shifted[15];
            2'd2:    sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
        ld_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ld_data[i] = (i < (8 << size_q)) ? shifted[i] : (signed_q & sign_bit);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_bad ? RSP : MEM;
            MEM:     if (i_mem_ack) state_nxt = (i_flush || flushed) ? IDLE : RSP;
            RSP:     if (i_rsp_ready || i_flush) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A flush seen at any point during MEM suppresses the eventual response.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            size_q     <= '0;
            signed_q   <= 1'b0;
            load_q     <= 1'b0;
            ofs_q      <= '0;
            flushed    <= 1'b0;
            o_mem_addr <= '0;
            o_mem_rd   <= 1'b0;
            o_mem_wr   <= '0;
            o_mem_dout <= '0;
            o_rsp_data <= '0;
            o_rsp_tag  <= '0;
            o_rsp_err  <= 1'b0;
        end else if (accept) begin
            size_q     <= i_req_size;
            signed_q   <= i_req_signed;
            load_q     <= i_req_load;
            ofs_q      <= req_ofs;
            flushed    <= 1'b0;
            o_rsp_tag  <= i_req_tag;
            o_rsp_data <= '0;
            if (req_bad) begin
                o_rsp_err <= 1'b1;
            end else begin
                o_rsp_err  <= 1'b0;
                o_mem_addr <= {i_req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                o_mem_rd   <= i_req_load;
                o_mem_wr   <= i_req_load ? '0 : wr_lanes;
                o_mem_dout <= i_req_load ? '0 : wr_data;
            end
        end else if (state == MEM) begin
            if (i_flush) begin
                flushed <= 1'b1;
            end
            if (i_mem_ack) begin
                o_mem_addr <= '0;
                o_mem_rd   <= 1'b0;
                o_mem_wr   <= '0;
                o_mem_dout <= '0;
                o_rsp_data <= load_q ? ld_data : '0;
                o_rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_gen.sv
// Directed scoreboard bench for lsu_gen, covering 32-bit and 64-bit instances.
module tb_lsu_gen;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_load = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [23:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_tag = '0;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_din = '0;
    logic        rsp_ready = 1'b0;
    bit          wide = 1'b0;

    logic        n_req_ready, n_mem_rd, n_rsp_valid, n_rsp_err;
    logic [23:0] n_mem_addr;
    logic [3:0]  n_mem_wr, n_rsp_tag;
    logic [31:0] n_mem_dout, n_rsp_data;
    logic        w_req_ready, w_mem_rd, w_rsp_valid, w_rsp_err;
    logic [23:0] w_mem_addr;
    logic [7:0]  w_mem_wr;
    logic [3:0]  w_rsp_tag;
    logic [63:0] w_mem_dout, w_rsp_data;

    logic        obs_req_ready, obs_mem_rd, obs_rsp_valid, obs_rsp_err;
    logic [23:0] obs_mem_addr;
    logic [7:0]  obs_mem_wr;
    logic [3:0]  obs_rsp_tag;
    logic [63:0] obs_mem_dout, obs_rsp_data;

    int   compared = 0;
    int   mismatched = 0;
    rsp_t sb[$];

    always #5 clk = ~clk;

    lsu_gen #(.DATA_W(32), .ADDR_W(24), .TAG_W(4)) dut32 (
        .i_clk(clk), .i_rstb(rstb), .i_flush(flush),
        .i_req_valid(req_valid && !wide), .o_req_ready(n_req_ready),
        .i_req_load(req_load), .i_req_size(req_size), .i_req_signed(req_signed),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata[31:0]), .i_req_tag(req_tag),
        .o_mem_addr(n_mem_addr), .o_mem_rd(n_mem_rd), .o_mem_wr(n_mem_wr),
        .o_mem_dout(n_mem_dout), .i_mem_ack(mem_ack && !wide), .i_mem_din(mem_din[31:0]),
        .o_rsp_valid(n_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(n_rsp_data),
        .o_rsp_tag(n_rsp_tag), .o_rsp_err(n_rsp_err)
    );

    lsu_gen #(.DATA_W(64), .ADDR_W(24), .TAG_W(4)) dut64 (
        .i_clk(clk), .i_rstb(rstb), .i_flush(flush),
        .i_req_valid(req_valid && wide), .o_req_ready(w_req_ready),
        .i_req_load(req_load), .i_req_size(req_size), .i_req_signed(req_signed),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_tag(req_tag),
        .o_mem_addr(w_mem_addr), .o_mem_rd(w_mem_rd), .o_mem_wr(w_mem_wr),
        .o_mem_dout(w_mem_dout), .i_mem_ack(mem_ack && wide), .i_mem_din(mem_din),
        .o_rsp_valid(w_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(w_rsp_data),
        .o_rsp_tag(w_rsp_tag), .o_rsp_err(w_rsp_err)
    );

    assign obs_req_ready = wide ? w_req_ready : n_req_ready;
    assign obs_mem_rd    = wide ? w_mem_rd    : n_mem_rd;
    assign obs_mem_addr  = wide ? w_mem_addr  : n_mem_addr;
    assign obs_mem_wr    = wide ? w_mem_wr    : {4'b0, n_mem_wr};
    assign obs_mem_dout  = wide ? w_mem_dout  : {32'b0, n_mem_dout};
    assign obs_rsp_valid = wide ? w_rsp_valid : n_rsp_valid;
    assign obs_rsp_data  = wide ? w_rsp_data  : {32'b0, n_rsp_data};
    assign obs_rsp_tag   = wide ? w_rsp_tag   : n_rsp_tag;
    assign obs_rsp_err   = wide ? w_rsp_err   : n_rsp_err;

    task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_strobes(input string name, input logic [23:0] maddr, input logic rd,
                                 input logic [7:0] wr, input logic [63:0] dout);
        check_output({name, "_addr"}, obs_mem_addr, maddr);
        check_output({name, "_rd"}, obs_mem_rd, rd);
        check_output({name, "_wr"}, obs_mem_wr, wr);
        if (!rd) check_output({name, "_dout"}, obs_mem_dout, dout);
    endtask

    task automatic check_rsp(input string name, input rsp_t exp);
        check_output({name, "_valid"}, obs_rsp_valid, 1'b1);
        check_output({name, "_data"}, obs_rsp_data, exp.data);
        check_output({name, "_tag"}, obs_rsp_tag, exp.tag);
        check_output({name, "_err"}, obs_rsp_err, exp.err);
    endtask

    // mode: 0 normal, 1 flush during MEM, 2 flush in RSP, 3 flush with ack
    task automatic apply_stimulus(
        input string name, input bit w, input logic load, input logic [1:0] size,
        input logic sgn, input logic [23:0] addr, input logic [63:0] wdata,
        input logic [3:0] tag, input bit bad, input logic [23:0] maddr,
        input logic [7:0] wr, input logic [63:0] dout, input int waits,
        input logic [63:0] din, input int bp, input int mode, input logic [63:0] exp_data);
        rsp_t exp;
        wide = w;
        #1;
        check_output({name, "_ready_idle"}, obs_req_ready, 1'b1);
        req_valid = 1'b1; req_load = load; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_tag = tag;
        if (mode == 0 || bad) sb.push_back('{data: exp_data, tag: tag, err: bad});
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (bad) begin
            check_output({name, "_no_rd"}, obs_mem_rd, 1'b0);
            check_output({name, "_no_wr"}, obs_mem_wr, 8'h00);
        end else begin
            check_strobes({name, "_s0"}, maddr, load, wr, dout);
            for (int i = 0; i < waits; i++) begin
                if (mode == 1 && i == 0) flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                check_strobes({name, "_hold"}, maddr, load, wr, dout);
            end
            mem_ack = 1'b1; mem_din = din;
            if (mode == 3) flush = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0; flush = 1'b0;
            check_output({name, "_rd_drop"}, obs_mem_rd, 1'b0);
            check_output({name, "_wr_drop"}, obs_mem_wr, 8'h00);
            if (mode == 1 || mode == 3) begin
                check_output({name, "_suppressed"}, obs_rsp_valid, 1'b0);
                check_output({name, "_ready_after"}, obs_req_ready, 1'b1);
                return;
            end
        end
        if (mode == 2) begin
            check_output({name, "_valid_pre"}, obs_rsp_valid, 1'b1);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            check_output({name, "_dropped"}, obs_rsp_valid, 1'b0);
            check_output({name, "_ready_after"}, obs_req_ready, 1'b1);
            return;
        end
        if (sb.size() == 0) begin
            check_output({name, "_sb_empty"}, 1'b1, 1'b0);
            return;
        end
        exp = sb.pop_front();
        for (int i = 0; i < bp; i++) begin
            check_rsp({name, "_bp"}, exp);
            check_output({name, "_bp_busy"}, obs_req_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        check_rsp(name, exp);
        check_output({name, "_busy_hs"}, obs_req_ready, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_output({name, "_valid_drop"}, obs_rsp_valid, 1'b0);
        check_output({name, "_ready_after"}, obs_req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #12;
        check_output("rst_ready32", n_req_ready, 1'b1);
        check_output("rst_ready64", w_req_ready, 1'b1);
        check_output("rst_valid32", n_rsp_valid, 1'b0);
        check_output("rst_rd32", n_mem_rd, 1'b0);
        check_output("rst_wr64", w_mem_wr, 8'h00);
        check_output("rst_data32", n_rsp_data, 32'h0);
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk);

        apply_stimulus("st_byte", 0, 0, 2'd0, 0, 24'h000003, 64'hA5, 4'h5, 0,
                       24'h000000, 8'b1000, 64'hA500_0000, 0, 64'h0, 0, 0, 64'h0);
        apply_stimulus("ld_half_s", 0, 1, 2'd1, 1, 24'h000102, 64'h0, 4'h3, 0,
                       24'h000100, 8'h00, 64'h0, 3, 64'h8001_1234, 0, 0, 64'hFFFF_8001);
        apply_stimulus("ld_half_u", 0, 1, 2'd1, 0, 24'h000102, 64'h0, 4'h4, 0,
                       24'h000100, 8'h00, 64'h0, 1, 64'h8001_1234, 0, 0, 64'h0000_8001);
        apply_stimulus("mis_word", 0, 1, 2'd2, 0, 24'h000006, 64'h0, 4'h6, 1,
                       24'h0, 8'h00, 64'h0, 0, 64'h0, 0, 0, 64'h0);
        apply_stimulus("ill_dword", 0, 1, 2'd3, 0, 24'h000000, 64'h0, 4'h7, 1,
                       24'h0, 8'h00, 64'h0, 0, 64'h0, 1, 0, 64'h0);
        apply_stimulus("mis_half_st", 0, 0, 2'd1, 0, 24'h000001, 64'h1234, 4'h8, 1,
                       24'h0, 8'h00, 64'h0, 0, 64'h0, 0, 0, 64'h0);
        apply_stimulus("ld_word_bp", 0, 1, 2'd2, 0, 24'h000010, 64'h0, 4'h9, 0,
                       24'h000010, 8'h00, 64'h0, 0, 64'hDEAD_BEEF, 5, 0, 64'hDEAD_BEEF);
        apply_stimulus("st_half", 0, 0, 2'd1, 0, 24'h000206, 64'h1234, 4'hA, 0,
                       24'h000204, 8'b1100, 64'h1234_0000, 1, 64'h0, 0, 0, 64'h0);
        apply_stimulus("ld_byte_pos", 0, 1, 2'd0, 1, 24'h000301, 64'h0, 4'hB, 0,
                       24'h000300, 8'h00, 64'h0, 0, 64'h0000_7F00, 0, 0, 64'h0000_007F);
        apply_stimulus("flush_mem", 0, 0, 2'd2, 0, 24'h000020, 64'h1122_3344, 4'hC, 0,
                       24'h000020, 8'b1111, 64'h1122_3344, 2, 64'h0, 0, 1, 64'h0);
        apply_stimulus("flush_rsp", 0, 1, 2'd2, 0, 24'h000024, 64'h0, 4'hD, 0,
                       24'h000024, 8'h00, 64'h0, 0, 64'h5555_AAAA, 0, 2, 64'h0);
        apply_stimulus("flush_ack", 0, 1, 2'd0, 0, 24'h000025, 64'h0, 4'hE, 0,
                       24'h000024, 8'h00, 64'h0, 1, 64'h0000_1200, 0, 3, 64'h0);
        apply_stimulus("after_flush", 0, 1, 2'd0, 0, 24'h000027, 64'h0, 4'hF, 0,
                       24'h000024, 8'h00, 64'h0, 0, 64'h9A00_0000, 0, 0, 64'h0000_009A);

        apply_stimulus("w_st_dword", 1, 0, 2'd3, 0, 24'h000008, 64'h0123_4567_89AB_CDEF, 4'h1, 0,
                       24'h000008, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0, 0, 64'h0);
        apply_stimulus("w_ld_byte7", 1, 1, 2'd0, 1, 24'h00000F, 64'h0, 4'h2, 0,
                       24'h000008, 8'h00, 64'h0, 2, 64'h8012_3456_789A_BCDE, 0, 0, 64'hFFFF_FFFF_FFFF_FF80);
        apply_stimulus("w_ld_word_hi", 1, 1, 2'd2, 0, 24'h000014, 64'h0, 4'h3, 0,
                       24'h000010, 8'h00, 64'h0, 0, 64'hCAFE_BABE_0000_0000, 2, 0, 64'h0000_0000_CAFE_BABE);
        apply_stimulus("w_st_half6", 1, 0, 2'd1, 0, 24'h000016, 64'hBEEF, 4'h4, 0,
                       24'h000010, 8'b1100_0000, 64'hBEEF_0000_0000_0000, 0, 64'h0, 0, 0, 64'h0);
        apply_stimulus("w_mis_dword", 1, 1, 2'd3, 0, 24'h00000C, 64'h0, 4'h5, 1,
                       24'h0, 8'h00, 64'h0, 0, 64'h0, 0, 0, 64'h0);

        wide = 1'b0;
        #1;
        req_valid = 1'b1; req_load = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 24'h000040; req_tag = 4'h6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("rstmid_rd_on", n_mem_rd, 1'b1);
        #2;
        rstb = 1'b0;
        #1;
        check_output("rstmid_rd_off", n_mem_rd, 1'b0);
        check_output("rstmid_addr", n_mem_addr, 24'h0);
        check_output("rstmid_ready", n_req_ready, 1'b1);
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk);
        apply_stimulus("post_rst", 0, 0, 2'd2, 0, 24'h000044, 64'hCAFE_F00D, 4'h7, 0,
                       24'h000044, 8'b1111, 64'hCAFE_F00D, 0, 64'h0, 0, 0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
